// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - register offsets, STATUS/CTRL bit indices and FSM state types for apb_usrt_core.
// USRT_PARITY_EN adds the PARITY states to both FSMs.
package usrt_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_OVF     = 5;
  localparam int ST_FRAME_ERR  = 6;
  localparam int ST_PARITY_ERR = 7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_PARITY = 2;

`ifdef USRT_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rxState_t;
`endif
endpackage

// File: rtl/usrt_fifo.sv
// rtl/usrt_fifo.sv - first-word-fall-through FIFO; a pop is applied before a push so a full FIFO
// accepts a simultaneous push and pop.
module usrt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      count;
  logic             doPush, doPop;

  assign full   = count == FULL_CNT;
  assign empty  = count == '0;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/apb_usrt_core.sv
// rtl/apb_usrt_core.sv - APB slave USRT master: register file, baud generator, TX and RX FSMs.
// USRT_PARITY_EN enables the optional even-parity bit (CTRL bit2, STATUS bit7).
module apb_usrt_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RST    = 3,
  parameter int ADDR_W     = 8
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSelect,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [ADDR_W-1:0] pAddress,
  input  logic [7:0]        pWData,
  output logic [7:0]        pRData,
  output logic              pReady,
  output logic              sClk,
  output logic              sOut,
  input  logic              sIn
);
  import usrt_pkg::*;

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic [1:0] addr;
  logic       wrEn, rdEn, unusedAddr;
  logic [2:0] ctrl;
  logic [7:0] divisor, divActive, baudCnt, w1c, status;
  logic       en, loopback, wrap, riseTick, fallTick, rxIn;
  logic       txOvf, rxOvf, frameErr, txOvfSet, rxOvfSet, frameSet, paritySet;

  logic [DATA_W-1:0] txHead, rxHead;
  logic txPushReq, txPop, txFull, txEmpty, rxPush, rxPop, rxFull, rxEmpty;

  txState_t txState, txNext;
  rxState_t rxState, rxNext;
  logic [CW-1:0]     txBit, txBitNext, rxBit, rxBitNext;
  logic [DATA_W-1:0] txShift, txShiftNext, rxShift, rxShiftNext;
  logic              sOutNext;

  assign addr       = pAddress[1:0];
  assign unusedAddr = ^pAddress[ADDR_W-1:2];
  assign wrEn       = pSelect && pEnable && pWrite;
  assign rdEn       = pSelect && pEnable && !pWrite;
  assign pReady     = 1'b1;
  assign en         = ctrl[CTRL_EN];
  assign loopback   = ctrl[CTRL_LOOP];
  assign rxIn       = loopback ? sOut : sIn;
  assign w1c        = (wrEn && addr == ADDR_STATUS) ? pWData : 8'h00;

  assign txPushReq = wrEn && addr == ADDR_DATA;
  assign rxPop     = rdEn && addr == ADDR_DATA && !rxEmpty;
  assign txOvfSet  = txPushReq && txFull && !txPop;
  assign rxOvfSet  = rxPush && rxFull && !rxPop;

  usrt_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk(pClk), .rst(pReset), .push(txPushReq), .pushData(pWData[DATA_W-1:0]),
    .pop(txPop), .head(txHead), .full(txFull), .empty(txEmpty));

  usrt_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk(pClk), .rst(pReset), .push(rxPush), .pushData(rxShift),
    .pop(rxPop), .head(rxHead), .full(rxFull), .empty(rxEmpty));

`ifdef USRT_PARITY_EN
  logic parityEn, parityErr, txPar, txParNext, rxParBad, rxParBadNext;
  assign parityEn = ctrl[CTRL_PARITY];
  assign status = {parityErr, frameErr, rxOvf, txOvf, rxFull, rxEmpty, txFull, txEmpty};
`else
  assign status = {1'b0, frameErr, rxOvf, txOvf, rxFull, rxEmpty, txFull, txEmpty};
`endif

  always_comb begin
    pRData = '0;
    if (pSelect && !pWrite) begin
      case (addr)
        ADDR_DATA:   if (!rxEmpty) pRData[DATA_W-1:0] = rxHead;
        ADDR_STATUS: pRData = status;
        ADDR_CTRL:   pRData = {5'b0, ctrl};
        default:     pRData = divisor;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as its W1C write wins.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      ctrl     <= '0;
      divisor  <= 8'(DIV_RST);
      txOvf    <= 1'b0;
      rxOvf    <= 1'b0;
      frameErr <= 1'b0;
`ifdef USRT_PARITY_EN
      parityErr <= 1'b0;
`endif
    end else begin
`ifdef USRT_PARITY_EN
      if (wrEn && addr == ADDR_CTRL) ctrl <= pWData[2:0];
      parityErr <= (parityErr & ~w1c[ST_PARITY_ERR]) | paritySet;
`else
      if (wrEn && addr == ADDR_CTRL) ctrl <= {1'b0, pWData[1:0]};
`endif
      if (wrEn && addr == ADDR_DIV) divisor <= pWData;
      txOvf    <= (txOvf & ~w1c[ST_TX_OVF]) | txOvfSet;
      rxOvf    <= (rxOvf & ~w1c[ST_RX_OVF]) | rxOvfSet;
      frameErr <= (frameErr & ~w1c[ST_FRAME_ERR]) | frameSet;
    end
  end

  // divActive latches DIVISOR only at a wrap (or while disabled) so a new value never cuts a half-period short.
  assign wrap     = en && baudCnt == divActive;
  assign riseTick = wrap && !sClk;
  assign fallTick = wrap && sClk;

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      baudCnt   <= '0;
      sClk      <= 1'b0;
      divActive <= 8'(DIV_RST);
    end else if (!en) begin
      baudCnt   <= '0;
      sClk      <= 1'b0;
      divActive <= divisor;
    end else if (wrap) begin
      baudCnt   <= '0;
      sClk      <= ~sClk;
      divActive <= divisor;
    end else begin
      baudCnt <= baudCnt + 1'b1;
    end
  end

  always_comb begin
    txNext      = txState;
    txBitNext   = txBit;
    txShiftNext = txShift;
    sOutNext    = sOut;
    txPop       = 1'b0;
`ifdef USRT_PARITY_EN
    txParNext   = txPar;
`endif
    if (!en) begin
      txNext   = TX_IDLE;
      sOutNext = 1'b1;
    end else if (fallTick) begin
      case (txState)
        TX_START: begin
          sOutNext    = txShift[0];
          txShiftNext = txShift >> 1;
          txBitNext   = '0;
          txNext      = TX_DATA;
        end
        TX_DATA: begin
          if (txBit == LAST_BIT) begin
            sOutNext = 1'b1;
            txNext   = TX_STOP;
`ifdef USRT_PARITY_EN
            if (parityEn) begin
              sOutNext = txPar;
              txNext   = TX_PARITY;
            end
`endif
          end else begin
            sOutNext    = txShift[0];
            txShiftNext = txShift >> 1;
            txBitNext   = txBit + 1'b1;
          end
        end
`ifdef USRT_PARITY_EN
        TX_PARITY: begin
          sOutNext = 1'b1;
          txNext   = TX_STOP;
        end
`endif
        default: begin
          // IDLE and the end of STOP: a queued byte starts at once, so frames run back to back.
          sOutNext = 1'b1;
          txNext   = TX_IDLE;
          if (!txEmpty) begin
            txPop       = 1'b1;
            txShiftNext = txHead;
            sOutNext    = 1'b0;
            txNext      = TX_START;
`ifdef USRT_PARITY_EN
            txParNext   = ^txHead;
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    rxNext      = rxState;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    rxPush      = 1'b0;
    frameSet    = 1'b0;
    paritySet   = 1'b0;
`ifdef USRT_PARITY_EN
    rxParBadNext = rxParBad;
`endif
    if (!en) begin
      rxNext = RX_IDLE;
    end else if (riseTick) begin
      case (rxState)
        RX_IDLE: begin
          if (!rxIn) begin
            rxNext    = RX_DATA;
            rxBitNext = '0;
`ifdef USRT_PARITY_EN
            rxParBadNext = 1'b0;
`endif
          end
        end
        RX_DATA: begin
          rxShiftNext = {rxIn, rxShift[DATA_W-1:1]};
          rxBitNext   = rxBit + 1'b1;
          if (rxBit == LAST_BIT) begin
            rxNext = RX_STOP;
`ifdef USRT_PARITY_EN
            if (parityEn) rxNext = RX_PARITY;
`endif
          end
        end
`ifdef USRT_PARITY_EN
        RX_PARITY: begin
          rxParBadNext = rxIn ^ (^rxShift);
          rxNext       = RX_STOP;
        end
`endif
        default: begin
          rxNext   = RX_IDLE;
          frameSet = !rxIn;
`ifdef USRT_PARITY_EN
          paritySet = rxParBad;
          rxPush    = rxIn && !rxParBad;
`else
          rxPush    = rxIn;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      txState <= TX_IDLE;
      txBit   <= '0;
      txShift <= '0;
      sOut    <= 1'b1;
      rxState <= RX_IDLE;
      rxBit   <= '0;
      rxShift <= '0;
`ifdef USRT_PARITY_EN
      txPar    <= 1'b0;
      rxParBad <= 1'b0;
`endif
    end else begin
      txState <= txNext;
      txBit   <= txBitNext;
      txShift <= txShiftNext;
      sOut    <= sOutNext;
      rxState <= rxNext;
      rxBit   <= rxBitNext;
      rxShift <= rxShiftNext;
`ifdef USRT_PARITY_EN
      txPar    <= txParNext;
      rxParBad <= rxParBadNext;
`endif
    end
  end
endmodule

// File: tb/tb_apb_usrt_core.sv
// tb/tb_apb_usrt_core.sv - scoreboard bench for apb_usrt_core (default build, parity disabled).
module tb_apb_usrt_core;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_RST    = 3;
  localparam int ADDR_W     = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

  logic              pClk = 1'b0;
  logic              pReset = 1'b1;
  logic              pSelect = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [ADDR_W-1:0] pAddress = '0;
  logic [7:0]        pWData = '0;
  logic [7:0]        pRData;
  logic              pReady, sClk, sOut;
  logic              sIn = 1'b1;

  int nCompared = 0;
  int nMismatched = 0;
  logic [7:0] expData[$];
  logic       expBits[$];

  apb_usrt_core #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_RST(DIV_RST), .ADDR_W(ADDR_W)) dut (
    .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
    .pAddress(pAddress), .pWData(pWData), .pRData(pRData), .pReady(pReady),
    .sClk(sClk), .sOut(sOut), .sIn(sIn));

  always #5 pClk = ~pClk;

  task automatic apbWrite(input logic [1:0] a, input logic [7:0] d);
    @(negedge pClk);
    pSelect = 1'b1; pWrite = 1'b1; pAddress = ADDR_W'(a); pWData = d; pEnable = 1'b0;
    @(negedge pClk);
    pEnable = 1'b1;
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask

  task automatic apbRead(input logic [1:0] a, output logic [7:0] d);
    @(negedge pClk);
    pSelect = 1'b1; pWrite = 1'b0; pAddress = ADDR_W'(a); pEnable = 1'b0;
    @(negedge pClk);
    pEnable = 1'b1;
    #1 d = pRData;
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0;
  endtask

  // Waits (sampling on pClk falling edges) until sClk changes to the given level.
  task automatic waitSclk(input logic level, input int budget, output bit ok);
    logic prev;
    prev = sClk;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pClk);
      if (prev !== level && sClk === level) begin
        ok = 1'b1;
        break;
      end
      prev = sClk;
    end
  endtask

  task automatic pushFrame(input logic [7:0] d);
    expBits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) expBits.push_back(d[i]);
    expBits.push_back(1'b1);
  endtask

  task automatic driveFrame(input logic [7:0] d, input logic stopBit, output bit ok);
    bit k;
    ok = 1'b1;
    waitSclk(1'b0, 100, k); ok &= k;
    sIn = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      waitSclk(1'b0, 100, k); ok &= k;
      sIn = d[i];
    end
    waitSclk(1'b0, 100, k); ok &= k;
    sIn = stopBit;
    waitSclk(1'b0, 100, k); ok &= k;
    sIn = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    pReset = 1'b1;
    repeat (3) @(negedge pClk);
    nCompared++; if (sOut !== 1'b1) begin nMismatched++; $display("FAIL reset_sOut: got %b want 1", sOut); end
    nCompared++; if (sClk !== 1'b0) begin nMismatched++; $display("FAIL reset_sClk: got %b want 0", sClk); end
    nCompared++; if (pReady !== 1'b1) begin nMismatched++; $display("FAIL reset_pReady: got %b want 1", pReady); end
    nCompared++; if (pRData !== 8'h00) begin nMismatched++; $display("FAIL reset_pRData: got %h want 00", pRData); end
    pReset = 1'b0;
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h05) begin nMismatched++; $display("FAIL reset_status: got %h want 05", v); end
    apbRead(A_CTRL, v);
    nCompared++; if (v !== 8'h00) begin nMismatched++; $display("FAIL reset_ctrl: got %h want 00", v); end
    apbRead(A_DIV, v);
    nCompared++; if (v !== 8'(DIV_RST)) begin nMismatched++; $display("FAIL reset_div: got %h want %h", v, 8'(DIV_RST)); end
  endtask

  task automatic test_loopback;
    logic [7:0] v, e;
    logic b;
    bit ok;
    time t0, t1;
    apbWrite(A_DIV, 8'h01);
    apbWrite(A_DATA, 8'hA5);
    pushFrame(8'hA5);
    expData.push_back(8'hA5);
    apbWrite(A_CTRL, 8'h03);
    for (int i = 0; i < 6; i++) begin
      waitSclk(1'b1, 40, ok);
      if (!ok || sOut === 1'b0) break;
    end
    nCompared++; if (!ok || sOut !== 1'b0) begin nMismatched++; $display("FAIL loop_start: got sOut=%b ok=%0d want start bit", sOut, ok); end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) waitSclk(1'b1, 40, ok);
      b = expBits.pop_front();
      nCompared++; if (!ok || sOut !== b) begin nMismatched++; $display("FAIL loop_bit%0d: got %b want %b", i, sOut, b); end
    end
    waitSclk(1'b1, 40, ok); t0 = $time;
    waitSclk(1'b1, 40, ok); t1 = $time;
    nCompared++; if (!ok || (t1 - t0) != 40) begin nMismatched++; $display("FAIL loop_period: got %0d want 40", t1 - t0); end
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h01) begin nMismatched++; $display("FAIL loop_status_rx: got %h want 01", v); end
    apbRead(A_DATA, v);
    e = expData.pop_front();
    nCompared++; if (v !== e) begin nMismatched++; $display("FAIL loop_data: got %h want %h", v, e); end
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h05) begin nMismatched++; $display("FAIL loop_status_after: got %h want 05", v); end
  endtask

  task automatic test_tx_overflow;
    logic [7:0] v, d;
    apbWrite(A_CTRL, 8'h00);
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      d = 8'(8'h11 * (i + 1));
      apbWrite(A_DATA, d);
      if (i < FIFO_DEPTH) expData.push_back(d);
    end
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h16) begin nMismatched++; $display("FAIL txovf_status: got %h want 16", v); end
    apbWrite(A_STATUS, 8'h10);
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h06) begin nMismatched++; $display("FAIL txovf_clear: got %h want 06", v); end
  endtask

  task automatic test_rx_overflow;
    logic [7:0] v, e;
    bit ok;
    apbWrite(A_CTRL, 8'h03);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      apbRead(A_STATUS, v);
      if (v[1] === 1'b0) begin ok = 1'b1; break; end
    end
    nCompared++; if (!ok) begin nMismatched++; $display("FAIL rxovf_txdrain: got status %h want txFull clear", v); end
    apbWrite(A_DATA, 8'h66);
    repeat (400) @(negedge pClk);
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h29) begin nMismatched++; $display("FAIL rxovf_status: got %h want 29", v); end
    apbWrite(A_CTRL, 8'h00);
    while (expData.size() > 0) begin
      apbRead(A_DATA, v);
      e = expData.pop_front();
      nCompared++; if (v !== e) begin nMismatched++; $display("FAIL rxovf_data: got %h want %h", v, e); end
    end
    apbRead(A_DATA, v);
    nCompared++; if (v !== 8'h00) begin nMismatched++; $display("FAIL rx_empty_read: got %h want 00", v); end
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h25) begin nMismatched++; $display("FAIL rx_empty_status: got %h want 25", v); end
    apbWrite(A_STATUS, 8'h20);
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h05) begin nMismatched++; $display("FAIL rxovf_clear: got %h want 05", v); end
  endtask

  task automatic test_frame_error;
    logic [7:0] v, e;
    bit ok;
    apbWrite(A_CTRL, 8'h01);
    driveFrame(8'h3C, 1'b1, ok);
    expData.push_back(8'h3C);
    nCompared++; if (!ok) begin nMismatched++; $display("FAIL rx_good_timeout: got no sClk want edges"); end
    apbRead(A_DATA, v);
    e = expData.pop_front();
    nCompared++; if (v !== e) begin nMismatched++; $display("FAIL rx_good_data: got %h want %h", v, e); end
    driveFrame(8'h81, 1'b0, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("FAIL rx_bad_timeout: got no sClk want edges"); end
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h45) begin nMismatched++; $display("FAIL frame_err_status: got %h want 45", v); end
    apbWrite(A_STATUS, 8'h40);
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h05) begin nMismatched++; $display("FAIL frame_err_clear: got %h want 05", v); end
  endtask

  task automatic test_en_clear;
    logic [7:0] v;
    logic b;
    bit ok;
    apbWrite(A_CTRL, 8'h00);
    apbWrite(A_DATA, 8'h5A);
    apbWrite(A_DATA, 8'hC3);
    pushFrame(8'hC3);
    apbWrite(A_CTRL, 8'h01);
    for (int i = 0; i < 6; i++) begin
      waitSclk(1'b1, 40, ok);
      if (!ok || sOut === 1'b0) break;
    end
    for (int i = 0; i < 4; i++) waitSclk(1'b1, 40, ok);
    nCompared++; if (!ok || sOut !== 1'b1) begin nMismatched++; $display("FAIL enclr_bit3: got %b want 1", sOut); end
    apbWrite(A_CTRL, 8'h00);
    @(negedge pClk);
    nCompared++; if (sOut !== 1'b1) begin nMismatched++; $display("FAIL enclr_sOut: got %b want 1", sOut); end
    nCompared++; if (sClk !== 1'b0) begin nMismatched++; $display("FAIL enclr_sClk: got %b want 0", sClk); end
    apbRead(A_STATUS, v);
    nCompared++; if (v !== 8'h04) begin nMismatched++; $display("FAIL enclr_status: got %h want 04", v); end
    apbWrite(A_CTRL, 8'h01);
    for (int i = 0; i < 6; i++) begin
      waitSclk(1'b1, 40, ok);
      if (!ok || sOut === 1'b0) break;
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) waitSclk(1'b1, 40, ok);
      b = expBits.pop_front();
      nCompared++; if (!ok || sOut !== b) begin nMismatched++; $display("FAIL reen_bit%0d: got %b want %b", i, sOut, b); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tx_overflow();
    test_rx_overflow();
    test_frame_error();
    test_en_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_usrt_core.md
Name: apb_usrt_core

Overview:
Parametrised APB-slave synchronous serial port (USRT master) with separate TX and RX FIFOs, a programmable bit-clock divisor, framing checks and sticky error flags. It supersedes the fixed 8-bit, unbuffered bridge.
- Sits between the APB bus (pClk domain) and the off-chip serial link.
- Generates the serial clock sClk itself; no second clock domain exists.

Parameters:
- DATA_W, 8, frame payload bits (5..8); lower bits of pWData/pRData are used, unused read bits are 0.
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16.
- DIV_RST, 3, reset value of the DIVISOR register.
- ADDR_W, 8, pAddress width; only pAddress[1:0] is decoded.

Ports:
- pClk, in, 1, system clock; all logic on its rising edge.
- pReset, in, 1, asynchronous active-high reset.
- pSelect, in, 1, APB select.
- pEnable, in, 1, APB access phase.
- pWrite, in, 1, 1 = write.
- pAddress, in, ADDR_W, register address.
- pWData, in, 8, write data.
- pRData, out, 8, read data.
- pReady, out, 1, constant 1 (zero wait states).
- sClk, out, 1, serial bit clock.
- sOut, out, 1, serial transmit data.
- sIn, in, 1, serial receive data; already synchronous to sClk.

Behaviour:
- Reset values: pRData=0, pReady=1, sClk=0, sOut=1, CTRL=0, DIVISOR=DIV_RST, FIFOs empty, sticky flags 0, both FSMs IDLE.
- Register map, by pAddress[1:0]:
  - 0 DATA: write pushes the TX FIFO; read returns the RX FIFO head and pops it.
  - 1 STATUS: bit0 txEmpty, 1 txFull, 2 rxEmpty, 3 rxFull, 4 txOvf, 5 rxOvf, 6 frameErr, 7 parityErr. Bits 4..7 are sticky and cleared by writing 1 (W1C).
  - 2 CTRL: bit0 en, bit1 loopback (sIn replaced internally by sOut).
  - 3 DIVISOR: 8 bits.
- APB transfer:
  - Completes on the cycle with pSelect & pEnable.
  - Register writes and FIFO push/pop happen at that cycle's end.
  - pRData is combinational from the addressed register or FIFO head while pSelect & !pWrite; otherwise 0.
- Baud generator (runs only while en=1):
  - 8-bit counter counts 0..DIVISOR, then wraps and toggles sClk.
  - sClk period is 2*(DIVISOR+1) pClk cycles; DIVISOR=0 gives period 2.
  - A DIVISOR write takes effect at the next wrap.
  - riseTick and fallTick are single-cycle strobes.
- Frame format: start bit 0, DATA_W bits LSB first, [parity], stop bit 1.
- TX FSM (IDLE, START, DATA, PARITY, STOP), advancing on fallTick:
  - IDLE with TX FIFO non-empty at fallTick: pop, drive 0, go to START.
  - Bit counter runs 0..DATA_W-1.
  - STOP drives 1, then returns to IDLE; back-to-back frames need no idle bit.
- RX FSM (IDLE, DATA, PARITY, STOP), sampling sIn on riseTick:
  - IDLE sampling 0 moves to DATA.
  - STOP sampling 0 sets frameErr and discards the byte; otherwise the byte is pushed to the RX FIFO.
- Boundary conditions:
  - DATA write while TX FIFO full: data dropped, txOvf set.
  - RX frame completes with RX FIFO full: byte dropped, rxOvf set. If an APB pop of the full FIFO happens in the same cycle, the pop is applied first and the push succeeds.
  - DATA read while RX FIFO empty: returns 0, no pop, no flag.
  - FIFO push and pop in the same cycle: both succeed, count unchanged.
  - W1C write in the same cycle as a flag-set event: set wins.
- Clearing en mid-frame:
  - Next cycle: counter and sClk return to 0, sOut=1, both FSMs go to IDLE.
  - The partial frame is lost; the popped TX byte is not restored.
  - FIFO contents are retained.
- pReset mid-frame returns everything to reset values immediately.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap; the count is one bit wider.

Optional Feature:
- Macro: USRT_PARITY_EN.
- Defined: CTRL bit2 enables an even-parity bit after the data bits.
  - TX sends the XOR of the data bits.
  - RX compares the received parity bit; on mismatch it sets parityErr and drops the byte.
  - A frame with both parity and stop errors sets both flags.
- Undefined: the PARITY states are absent, CTRL bit2 reads 0 and is ignored, and STATUS bit7 reads 0.

Decomposition:
- Package usrt_pkg holds:
  - Register offsets: ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_DIV=3.
  - STATUS and CTRL bit-index constants.
  - The TX and RX state enums.
- Sub-module usrt_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head, first-word-fall-through), instantiated once for TX and once for RX.
- Baud generator and both FSMs live in apb_usrt_core.

Test Plan:
- Reset, then read STATUS, CTRL and DIVISOR -> 0x05, 0x00, DIV_RST; sOut=1, sClk=0.
- Set DIVISOR=1, CTRL=0x03 (en, loopback), write DATA 0xA5 -> sClk period 4 pClk; sOut bit sequence 0,1,0,1,0,0,1,0,1,1; RX FIFO then holds 0xA5; reading DATA returns 0xA5 and STATUS becomes 0x05.
- With en=0, write FIFO_DEPTH+1 bytes -> STATUS bits 1 and 4 set; write STATUS 0x10 -> bit4 clears.
- Loopback with 5 frames received and none read (FIFO_DEPTH=4) -> rxFull and rxOvf set; the first 4 bytes read back in order, the 5th lost.
- en=1, no loopback, drive sIn start bit, 8 data bits and stop bit 0 -> frameErr set, RX FIFO still empty.
- Clear en during TX bit 3 -> within 1 cycle sOut=1 and sClk=0; re-enable -> the next queued byte is sent as a complete frame.
